// File: rtl/d_mem.sv
// -----------------------------------------------------------------------------
// d_mem -- data memory for the single-cycle RISC-V core (memory stage).
//
// 32 words x 32 bits, word-addressed by a 5-bit index. Stores are synchronous
// (one word per rising clk_i when MemRW is high); loads are combinational, so
// dataR always reflects mem[addr]. An asynchronous active-low reset clears
// the whole array and holds it at zero while asserted.
//
// Ports
//   clk_i   in   1   system clock, writes on rising edge
//   rst_ni  in   1   asynchronous active-low reset, clears every word
//   MemRW   in   1   1 = write dataW to mem[addr] at next rising edge
//   addr    in   5   word index 0..31, shared by read and write
//   dataW   in  32   write data
//   dataR   out 32   read data, always mem[addr]
// -----------------------------------------------------------------------------
module d_mem (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        MemRW,
  input  logic [4:0]  addr,
  input  logic [31:0] dataW,
  output logic [31:0] dataR
);

  localparam int unsigned DEPTH = 32;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] w_rd_data;

  // Storage array: asynchronous clear to zero, otherwise one-word write per edge.
  // The clear branch also wins at any edge seen while rst_ni is low, so a
  // write attempted during reset is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (MemRW) begin
      r_mem[addr] <= dataW;
    end else begin
      r_mem[addr] <= r_mem[addr];
    end
  end

  // Combinational read port: no enable, no output register, no write bypass.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    w_rd_data = r_mem[addr];
  end

  assign dataR = w_rd_data;

endmodule

// File: tb/tb_d_mem.sv
// -----------------------------------------------------------------------------
// tb_d_mem -- self-checking bench for d_mem.
// Expected read values are pushed to a scoreboard queue as stimulus is
// applied and popped/compared when dataR is sampled. A bench-side model
// array tracks the intended memory contents.
// -----------------------------------------------------------------------------
module tb_d_mem;

  logic        clk_i;
  logic        rst_ni;
  logic        MemRW;
  logic [4:0]  addr;
  logic [31:0] dataW;
  logic [31:0] dataR;

  logic [31:0] model [0:31];
  logic [31:0] exp_q [$];
  logic [31:0] exp;
  int          checks;
  int          errors;

  d_mem dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .MemRW (MemRW),
    .addr  (addr),
    .dataW (dataW),
    .dataR (dataR)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Drive one write; it lands at the next rising edge. Inputs change on the
  // falling edge so they are stable around the active edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_i);
    MemRW = 1'b1;
    addr  = a;
    dataW = d;
    @(posedge clk_i);
    model[a] = d;
    #1;
  endtask

  task automatic idle_bus();
    @(negedge clk_i);
    MemRW = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    #2;
    rst_ni = 1'b0;
    MemRW  = 1'b1;
    dataW  = 32'hFFFF_FFFF;
    clear_model();
    // Sweep spans three rising edges with MemRW high while in reset
    for (int i = 0; i < 32; i++) begin
      addr = i[4:0];
      exp_q.push_back(32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataR !== exp) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d got=%h exp=%h", i, dataR, exp);
      end
    end
    MemRW = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      addr = i[4:0];
      exp_q.push_back(model[i]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataR !== exp) begin
        errors++;
        $display("FAIL reset_no_write addr=%0d got=%h exp=%h", i, dataR, exp);
      end
    end
  endtask

  task automatic test_seq_write_read();
    logic [31:0] vals [0:3];
    vals[0] = 32'hA5A5_A5A5;
    vals[1] = 32'h5A5A_5A5A;
    vals[2] = 32'h1234_5678;
    vals[3] = 32'h8765_4321;
    for (int i = 0; i < 4; i++) do_write(i[4:0], vals[i]);
    idle_bus();
    for (int i = 0; i < 5; i++) begin
      addr = i[4:0];
      exp_q.push_back((i < 4) ? vals[i] : 32'h0);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataR !== exp) begin
        errors++;
        $display("FAIL seq_read addr=%0d got=%h exp=%h", i, dataR, exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk_i);
    MemRW = 1'b1;
    addr  = 5'd7;
    dataW = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL rdw_before got=%h exp=%h", dataR, exp);
    end
    @(posedge clk_i);
    model[7] = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL rdw_after got=%h exp=%h", dataR, exp);
    end
    idle_bus();
  endtask

  task automatic test_overwrite();
    do_write(5'd31, 32'h1111_1111);
    exp_q.push_back(32'h1111_1111);
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL overwrite_first got=%h exp=%h", dataR, exp);
    end
    do_write(5'd31, 32'h2222_2222);
    exp_q.push_back(32'h2222_2222);
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL overwrite_second got=%h exp=%h", dataR, exp);
    end
    do_write(5'd0, 32'hCAFE_0000);
    idle_bus();
    addr = 5'd31;
    exp_q.push_back(32'h2222_2222);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL overwrite_neighbor addr=31 got=%h exp=%h", dataR, exp);
    end
    addr = 5'd0;
    exp_q.push_back(32'hCAFE_0000);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL overwrite_addr0 got=%h exp=%h", dataR, exp);
    end
  endtask

  task automatic test_no_write();
    @(negedge clk_i);
    MemRW = 1'b0;
    for (int i = 0; i < 12; i++) begin
      addr  = 5'($urandom_range(0, 31));
      dataW = $urandom();
      @(negedge clk_i);
    end
    for (int i = 0; i < 32; i++) begin
      addr = i[4:0];
      exp_q.push_back(model[i]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataR !== exp) begin
        errors++;
        $display("FAIL no_write addr=%0d got=%h exp=%h", i, dataR, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd5, 32'h0000_0005);
    do_write(5'd6, 32'h0000_0006);
    do_write(5'd5, 32'h5555_0005);
    idle_bus();
    for (int i = 5; i < 7; i++) begin
      addr = i[4:0];
      exp_q.push_back((i == 5) ? 32'h5555_0005 : 32'h0000_0006);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataR !== exp) begin
        errors++;
        $display("FAIL back_to_back addr=%0d got=%h exp=%h", i, dataR, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    do_write(5'd10, 32'h0A0A_0A0A);
    do_write(5'd11, 32'h0B0B_0B0B);
    do_write(5'd12, 32'h0C0C_0C0C);
    @(negedge clk_i);
    MemRW = 1'b0;
    addr  = 5'd11;
    #1;
    exp_q.push_back(32'h0B0B_0B0B);
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL async_pre got=%h exp=%h", dataR, exp);
    end
    // Reset drops 1 time unit later, well before the next rising edge
    #1;
    rst_ni = 1'b0;
    clear_model();
    exp_q.push_back(32'h0);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL async_drop got=%h exp=%h", dataR, exp);
    end
    // A write attempted across an edge while still in reset must be lost
    MemRW = 1'b1;
    addr  = 5'd12;
    dataW = 32'h7777_7777;
    @(posedge clk_i);
    @(negedge clk_i);
    MemRW  = 1'b0;
    rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      addr = i[4:0];
      exp_q.push_back(model[i]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataR !== exp) begin
        errors++;
        $display("FAIL async_after addr=%0d got=%h exp=%h", i, dataR, exp);
      end
    end
    // First edge after release accepts a write
    do_write(5'd3, 32'h3333_3333);
    exp_q.push_back(32'h3333_3333);
    exp = exp_q.pop_front();
    checks++;
    if (dataR !== exp) begin
      errors++;
      $display("FAIL first_write_after_reset got=%h exp=%h", dataR, exp);
    end
    idle_bus();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b1;
    MemRW  = 1'b0;
    addr   = 5'd0;
    dataW  = 32'h0;
    clear_model();
    test_reset();
    test_seq_write_read();
    test_read_during_write();
    test_overwrite();
    test_back_to_back();
    test_no_write();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
